ttc_cmd_gen: RTL and testbench
==============================

// Module: ttc_cmd_gen
// PURPOSE
//  Local TTC command generator: drives the bx0, resync and L1A strobes consumed by the
//  bunch-crossing/orbit counter logic. Used for standalone running and self-test when no
//  backplane TTC is present. Keeps a fixed orbit phase and never emits resync in a bx0 cycle.
//  L1As obey a minimum spacing. Requests come from the slow-control register block.
// PARAMETERS
//  MXBXN         12     BXN width
//  LHC_CYCLE     3564   orbit length in clocks; BXN runs 0..LHC_CYCLE-1
//  MXCNT         32     orbit_counter / l1a_counter width
//  RESYNC_QUIET  400    L1A inhibit window, in clocks, after a resync
//  L1A_MIN_GAP   3      minimum distance b-a between L1As at cycles a<b (>=1)
// PORTS
//  clock           in   1      40 MHz clock
//  reset           in   1      synchronous, active-high
//  enable          in   1      1=generate, 0=idle
//  resync_req      in   1      one-clock request to issue a resync
//  l1a_req         in   1      one-clock request for a single L1A
//  l1a_period      in   16     periodic L1A interval in clocks; 0=off
//  ttc_bx0         out  1      bx0 strobe
//  ttc_resync      out  1      resync strobe
//  ttc_l1a         out  1      L1A strobe
//  bxn_counter     out  MXBXN  generator BXN
//  orbit_counter   out  MXCNT  bx0s issued since the last resync; saturating
//  l1a_counter     out  MXCNT  L1As issued since the last resync; saturating
//  l1a_lost        out  16     L1A requests dropped; saturating; cleared only by reset
//  resync_pending  out  1      resync latched but not yet issued
// BEHAVIOUR
//  - All outputs registered. Reset value of every output and counter is 0. State resets to IDLE.
//  - States: IDLE, RUN, RSY_WAIT, QUIET.
//    IDLE: bxn_counter=0, no strobes. enable sampled 1 -> RUN.
//    Next cycle: bxn_counter=0 and ttc_bx0=1.
//  - Outside IDLE, bxn_counter counts 0..LHC_CYCLE-1 and wraps to 0.
//    ttc_bx0=1 exactly when bxn_counter==0.
//  - resync_req sampled in RUN -> RSY_WAIT, resync_pending=1. Issue slot: ttc_resync=1 in the
//    first cycle with bxn_counter==LHC_CYCLE-1 that is strictly after the sampling cycle.
//    A request sampled at bxn 3563 therefore goes out one orbit later.
//    The next cycle carries bx0, so orbit phase is unchanged and resync never coincides with bx0.
//  - On the resync cycle: orbit_counter and l1a_counter load 0, pending L1A is cleared,
//    state -> QUIET for RESYNC_QUIET clocks.
//  - resync_req in RSY_WAIT merges into the existing request. resync_req in QUIET is latched
//    (resync_pending=1); at the end of QUIET the state goes to RSY_WAIT instead of RUN.
//  - orbit_counter += 1 on each ttc_bx0, saturating at all-ones. l1a_counter += 1 on each
//    ttc_l1a, saturating.
//  - L1A source: l1a_req OR a periodic tick. The tick fires every l1a_period clocks in RUN.
//    The period counter restarts on enable rise or on a l1a_period change.
//  - One-deep pending flag. A request with the flag already set increments l1a_lost.
//  - Pending L1A issues when not in QUIET, not in IDLE, and L1A_MIN_GAP has elapsed since the
//    last L1A. Minimum latency: request at cycle n -> ttc_l1a at n+1.
//  - A request in QUIET stays pending and issues on the first cycle after QUIET ends.
//  - L1A may coincide with bx0 or resync (separate channels).
//  - enable sampled 0 in any state -> IDLE next cycle: strobes 0, bxn 0, pending resync and
//    pending L1A cleared, counters held.
//  - reset mid-operation: everything returns to reset values the next cycle.
// CONFIGURATION
//  TTC_CMD_GEN_PERIODIC_L1A_EN defined: periodic tick generator built as described above.
//  Not defined: l1a_period is ignored and only l1a_req produces L1As; all other behaviour is identical.
// TESTING
//  1 reset, enable=1 for 2*3564+1 clk -> bx0 at bxn 0 every 3564 clk, orbit_counter=3, no resync/l1a.
//  2 resync_req at bxn 100 -> ttc_resync at bxn 3563 same orbit, bx0 next clk, orbit_counter=1 after it.
//    l1a_req 10 clk after resync -> ttc_l1a in clk 400 after the resync.
//  3 L1A_MIN_GAP=4, l1a_req at n,n+1,n+2 -> ttc_l1a at n+1 and n+5, l1a_lost=1, l1a_counter=2.
//  4 l1a_period=10 for 1000 clk in RUN -> 100 L1As. Macro undefined -> 0 L1As.
//  5 resync_req at bxn 3563 -> resync one orbit later. enable=0 in RSY_WAIT -> no resync, pending=0.
//  6 reset pulse during QUIET -> all outputs 0 next clk; after reset, enable=1 -> bx0 in the 1st RUN clk.

Source files
------------

// File: rtl/ttc_cmd_gen_if.sv
// Request/strobe bundle between the slow-control side and the local TTC
// command generator. The master drives the requests. The slave (the generator)
// drives the strobes, counters and status.
interface ttc_cmd_gen_if #(
    parameter int MXBXN = 12,
    parameter int MXCNT = 32
);
    logic             enable;
    logic             resync_req;
    logic             l1a_req;
    logic [15:0]      l1a_period;
    logic             ttc_bx0;
    logic             ttc_resync;
    logic             ttc_l1a;
    logic [MXBXN-1:0] bxn_counter;
    logic [MXCNT-1:0] orbit_counter;
    logic [MXCNT-1:0] l1a_counter;
    logic [15:0]      l1a_lost;
    logic             resync_pending;

    modport master (
        output enable, resync_req, l1a_req, l1a_period,
        input  ttc_bx0, ttc_resync, ttc_l1a, bxn_counter, orbit_counter,
               l1a_counter, l1a_lost, resync_pending
    );

    modport slave (
        input  enable, resync_req, l1a_req, l1a_period,
        output ttc_bx0, ttc_resync, ttc_l1a, bxn_counter, orbit_counter,
               l1a_counter, l1a_lost, resync_pending
    );
endinterface

// File: rtl/ttc_cmd_gen.sv
// Local TTC command generator. It produces the bx0, resync and L1A strobes for
// standalone running and self-test. The orbit phase is fixed: a resync is
// always placed on the last BXN of an orbit, so it never lands on a bx0. After
// a resync, L1As are inhibited for RESYNC_QUIET clocks. L1As also keep a
// minimum spacing of L1A_MIN_GAP clocks.
// Optional feature macro: TTC_CMD_GEN_PERIODIC_L1A_EN builds the periodic L1A
// tick generator. When the macro is not defined, l1a_period is ignored.
module ttc_cmd_gen #(
    parameter int MXBXN        = 12,
    parameter int LHC_CYCLE    = 3564,
    parameter int MXCNT        = 32,
    parameter int RESYNC_QUIET = 400,
    parameter int L1A_MIN_GAP  = 3
) (
    input  logic         clock,
    input  logic         reset,
    ttc_cmd_gen_if.slave ttc
);
    localparam int QW = $clog2(RESYNC_QUIET + 1);
    localparam int GW = $clog2(L1A_MIN_GAP + 1);
    localparam logic [MXBXN-1:0] BXN_LAST   = MXBXN'(LHC_CYCLE - 1);
    localparam logic [QW-1:0]    QUIET_LOAD = QW'(RESYNC_QUIET - 1);
    localparam logic [GW-1:0]    GAP_SAT    = GW'(L1A_MIN_GAP - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RSY_WAIT = 2'd2,
        QUIET    = 2'd3
    } state_t;

    state_t           state_r;
    state_t           nxt_state_s;
    logic [MXBXN-1:0] bxn_r;
    logic [MXBXN-1:0] nxt_bxn_s;
    logic [QW-1:0]    quiet_r;
    logic [GW-1:0]    since_r;
    logic             rsy_pend_r;
    logic             l1a_pend_r;
    logic             bx0_r;
    logic             resync_r;
    logic             l1a_r;
    logic [MXCNT-1:0] orbit_r;
    logic [MXCNT-1:0] l1a_cnt_r;
    logic [15:0]      lost_r;

    logic             issue_rsy_s;
    logic             nxt_rsy_pend_s;
    logic             nxt_bx0_s;
    logic             src_s;
    logic             want_s;
    logic             gap_ok_s;
    logic             active_s;
    logic             issue_l1a_s;
    logic             lost_s;
    logic             nxt_l1a_pend_s;
    logic             tick_s;

    function automatic logic [MXCNT-1:0] sat_inc_cnt(input logic [MXCNT-1:0] v);
        return (&v) ? v : (v + MXCNT'(1));
    endfunction

    function automatic logic [15:0] sat_inc_lost(input logic [15:0] v);
        return (&v) ? v : (v + 16'd1);
    endfunction

`ifdef TTC_CMD_GEN_PERIODIC_L1A_EN
    logic [15:0] per_cnt_r;
    logic [15:0] per_val_r;

    // The periodic tick fires in RUN when the interval counter reaches period-1.
    always_comb begin
        tick_s = 1'b0;
        if ((state_r == RUN) && (ttc.l1a_period != 16'd0) &&
            (ttc.l1a_period == per_val_r) &&
            (per_cnt_r == (ttc.l1a_period - 16'd1))) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // The interval counter is held at 0 in IDLE, so it restarts on an enable rise.
    // It also restarts whenever the programmed period changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            per_cnt_r <= 16'd0;
            per_val_r <= 16'd0;
        end else begin
            per_val_r <= ttc.l1a_period;
            if ((state_r == IDLE) || (ttc.l1a_period != per_val_r) ||
                (ttc.l1a_period == 16'd0)) begin
                per_cnt_r <= 16'd0;
            end else if (per_cnt_r == (ttc.l1a_period - 16'd1)) begin
                per_cnt_r <= 16'd0;
            end else begin
                per_cnt_r <= per_cnt_r + 16'd1;
            end
        end
    end
`else
    logic unused_period_s;
    assign tick_s          = 1'b0;
    assign unused_period_s = ^ttc.l1a_period;
`endif

    // Next-state, next-BXN and resync slot selection. A resync goes out on the
    // next cycle whose BXN is the last of the orbit.
    always_comb begin
        nxt_state_s = state_r;
        nxt_bxn_s   = {MXBXN{1'b0}};
        issue_rsy_s = 1'b0;
        if (!ttc.enable || (state_r == IDLE)) begin
            nxt_bxn_s = {MXBXN{1'b0}};
        end else if (bxn_r == BXN_LAST) begin
            nxt_bxn_s = {MXBXN{1'b0}};
        end else begin
            nxt_bxn_s = bxn_r + MXBXN'(1);
        end
        if (!ttc.enable) begin
            nxt_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: nxt_state_s = RUN;
                RUN: begin
                    if (ttc.resync_req && (nxt_bxn_s == BXN_LAST)) begin
                        issue_rsy_s = 1'b1;
                        nxt_state_s = QUIET;
                    end else if (ttc.resync_req) begin
                        nxt_state_s = RSY_WAIT;
                    end else begin
                        nxt_state_s = RUN;
                    end
                end
                RSY_WAIT: begin
                    if (nxt_bxn_s == BXN_LAST) begin
                        issue_rsy_s = 1'b1;
                        nxt_state_s = QUIET;
                    end else begin
                        nxt_state_s = RSY_WAIT;
                    end
                end
                QUIET: begin
                    if ((quiet_r == {QW{1'b0}}) && (rsy_pend_r || ttc.resync_req)) begin
                        nxt_state_s = RSY_WAIT;
                    end else if (quiet_r == {QW{1'b0}}) begin
                        nxt_state_s = RUN;
                    end else begin
                        nxt_state_s = QUIET;
                    end
                end
                default: nxt_state_s = IDLE;
            endcase
        end
        nxt_bx0_s = (nxt_state_s != IDLE) && (nxt_bxn_s == {MXBXN{1'b0}});
        if ((nxt_state_s == IDLE) || issue_rsy_s) begin
            nxt_rsy_pend_s = 1'b0;
        end else if ((state_r != IDLE) && ttc.resync_req) begin
            nxt_rsy_pend_s = 1'b1;
        end else begin
            nxt_rsy_pend_s = rsy_pend_r;
        end
    end

    // L1A arbitration. A one-deep pending flag holds a request. A request that
    // arrives while the flag is already set is counted as lost. An L1A goes out
    // only in an active cycle (RUN or RSY_WAIT) and only once the gap has elapsed.
    always_comb begin
        src_s       = ttc.l1a_req | tick_s;
        want_s      = l1a_pend_r | src_s;
        gap_ok_s    = (since_r >= GAP_SAT);
        active_s    = (nxt_state_s == RUN) || (nxt_state_s == RSY_WAIT);
        issue_l1a_s = active_s && want_s && gap_ok_s;
        lost_s      = src_s && l1a_pend_r && (nxt_state_s != IDLE);
        if ((nxt_state_s == IDLE) || issue_rsy_s || issue_l1a_s) begin
            nxt_l1a_pend_s = 1'b0;
        end else begin
            nxt_l1a_pend_s = want_s;
        end
    end

    // State, counters and registered strobes. Reset is synchronous.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            bxn_r      <= {MXBXN{1'b0}};
            quiet_r    <= {QW{1'b0}};
            since_r    <= GAP_SAT;
            rsy_pend_r <= 1'b0;
            l1a_pend_r <= 1'b0;
            bx0_r      <= 1'b0;
            resync_r   <= 1'b0;
            l1a_r      <= 1'b0;
            orbit_r    <= {MXCNT{1'b0}};
            l1a_cnt_r  <= {MXCNT{1'b0}};
            lost_r     <= 16'd0;
        end else begin
            state_r    <= nxt_state_s;
            bxn_r      <= nxt_bxn_s;
            rsy_pend_r <= nxt_rsy_pend_s;
            l1a_pend_r <= nxt_l1a_pend_s;
            bx0_r      <= nxt_bx0_s;
            resync_r   <= issue_rsy_s;
            l1a_r      <= issue_l1a_s;
            if (issue_rsy_s) begin
                quiet_r <= QUIET_LOAD;
            end else if ((state_r == QUIET) && (quiet_r != {QW{1'b0}})) begin
                quiet_r <= quiet_r - QW'(1);
            end else begin
                quiet_r <= quiet_r;
            end
            if (issue_l1a_s) begin
                since_r <= {GW{1'b0}};
            end else if (since_r >= GAP_SAT) begin
                since_r <= GAP_SAT;
            end else begin
                since_r <= since_r + GW'(1);
            end
            if (issue_rsy_s) begin
                orbit_r <= {MXCNT{1'b0}};
            end else if (nxt_bx0_s) begin
                orbit_r <= sat_inc_cnt(orbit_r);
            end else begin
                orbit_r <= orbit_r;
            end
            if (issue_rsy_s) begin
                l1a_cnt_r <= {MXCNT{1'b0}};
            end else if (issue_l1a_s) begin
                l1a_cnt_r <= sat_inc_cnt(l1a_cnt_r);
            end else begin
                l1a_cnt_r <= l1a_cnt_r;
            end
            if (lost_s) begin
                lost_r <= sat_inc_lost(lost_r);
            end else begin
                lost_r <= lost_r;
            end
        end
    end

    assign ttc.ttc_bx0        = bx0_r;
    assign ttc.ttc_resync     = resync_r;
    assign ttc.ttc_l1a        = l1a_r;
    assign ttc.bxn_counter    = bxn_r;
    assign ttc.orbit_counter  = orbit_r;
    assign ttc.l1a_counter    = l1a_cnt_r;
    assign ttc.l1a_lost       = lost_r;
    assign ttc.resync_pending = rsy_pend_r;
endmodule

// File: tb/tb_ttc_cmd_gen.sv
// Directed bench for ttc_cmd_gen. It runs with L1A_MIN_GAP=4 and the other
// parameters at their defaults. A cycle table covers start-up, L1A spacing,
// lost requests and the enable drop. Hand-written sequences cover orbit timing,
// resync placement, the quiet window, the periodic tick and a reset taken
// during QUIET.
module tb_ttc_cmd_gen;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

`ifdef TTC_CMD_GEN_PERIODIC_L1A_EN
    localparam int EXP_PER = 100;
`else
    localparam int EXP_PER = 0;
`endif

    ttc_cmd_gen_if #(.MXBXN(12), .MXCNT(32)) ttc ();

    ttc_cmd_gen #(
        .MXBXN(12), .LHC_CYCLE(3564), .MXCNT(32), .RESYNC_QUIET(400), .L1A_MIN_GAP(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ttc  (ttc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        en;
        logic        req;
        logic [11:0] bxn;
        logic        bx0;
        logic        l1a;
        logic [31:0] cnt;
        logic [15:0] lost;
        logic [31:0] orbit;
    } vec_t;

    vec_t tbl [17];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_bxn(input int target, input int budget);
        int n;
        n = 0;
        while ((ttc.bxn_counter != 12'(target)) && (n < budget)) begin
            tick();
            n++;
        end
        chk("wait_bxn_reached", 32'(ttc.bxn_counter), 32'(target));
    endtask

    task automatic wait_resync(input int budget, output int n);
        n = 0;
        while (!ttc.ttc_resync && (n < budget)) begin
            tick();
            n++;
        end
        chk("wait_resync_seen", 32'(ttc.ttc_resync), 32'd1);
    endtask

    initial begin
        int n;
        int err;
        int nbx0;
        int nrsy;
        int nl1a;
        int first;
        int exp_bxn;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        ttc.enable = 1'b0;
        ttc.resync_req = 1'b0;
        ttc.l1a_req = 1'b0;
        ttc.l1a_period = 16'd0;

        //              en    req   bxn     bx0   l1a   cnt    lost   orbit
        tbl[0]  = '{1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 32'd0, 16'd0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 12'd0,  1'b1, 1'b0, 32'd0, 16'd0, 32'd1};
        tbl[2]  = '{1'b1, 1'b0, 12'd1,  1'b0, 1'b0, 32'd0, 16'd0, 32'd1};
        tbl[3]  = '{1'b1, 1'b1, 12'd2,  1'b0, 1'b1, 32'd1, 16'd0, 32'd1};
        tbl[4]  = '{1'b1, 1'b1, 12'd3,  1'b0, 1'b0, 32'd1, 16'd0, 32'd1};
        tbl[5]  = '{1'b1, 1'b1, 12'd4,  1'b0, 1'b0, 32'd1, 16'd1, 32'd1};
        tbl[6]  = '{1'b1, 1'b0, 12'd5,  1'b0, 1'b0, 32'd1, 16'd1, 32'd1};
        tbl[7]  = '{1'b1, 1'b0, 12'd6,  1'b0, 1'b1, 32'd2, 16'd1, 32'd1};
        tbl[8]  = '{1'b1, 1'b0, 12'd7,  1'b0, 1'b0, 32'd2, 16'd1, 32'd1};
        tbl[9]  = '{1'b1, 1'b1, 12'd8,  1'b0, 1'b0, 32'd2, 16'd1, 32'd1};
        tbl[10] = '{1'b1, 1'b0, 12'd9,  1'b0, 1'b0, 32'd2, 16'd1, 32'd1};
        tbl[11] = '{1'b1, 1'b0, 12'd10, 1'b0, 1'b1, 32'd3, 16'd1, 32'd1};
        tbl[12] = '{1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 32'd3, 16'd1, 32'd1};
        tbl[13] = '{1'b1, 1'b0, 12'd0,  1'b1, 1'b0, 32'd3, 16'd1, 32'd2};
        tbl[14] = '{1'b1, 1'b1, 12'd1,  1'b0, 1'b0, 32'd3, 16'd1, 32'd2};
        tbl[15] = '{1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 32'd3, 16'd1, 32'd2};
        tbl[16] = '{1'b1, 1'b0, 12'd0,  1'b1, 1'b0, 32'd3, 16'd1, 32'd3};

        // Reset state
        tick();
        tick();
        chk("rst_bx0", 32'(ttc.ttc_bx0), 32'd0);
        chk("rst_resync", 32'(ttc.ttc_resync), 32'd0);
        chk("rst_l1a", 32'(ttc.ttc_l1a), 32'd0);
        chk("rst_bxn", 32'(ttc.bxn_counter), 32'd0);
        chk("rst_orbit", ttc.orbit_counter, 32'd0);
        chk("rst_l1a_cnt", ttc.l1a_counter, 32'd0);
        chk("rst_lost", 32'(ttc.l1a_lost), 32'd0);
        chk("rst_pending", 32'(ttc.resync_pending), 32'd0);
        reset = 1'b0;

        // Table: start-up, L1A gap of 4, lost request, enable drop clears pending
        for (int i = 0; i < 17; i++) begin
            ttc.enable  = tbl[i].en;
            ttc.l1a_req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_bxn", i), 32'(ttc.bxn_counter), 32'(tbl[i].bxn));
            chk($sformatf("tbl%0d_bx0", i), 32'(ttc.ttc_bx0), 32'(tbl[i].bx0));
            chk($sformatf("tbl%0d_l1a", i), 32'(ttc.ttc_l1a), 32'(tbl[i].l1a));
            chk($sformatf("tbl%0d_l1a_cnt", i), ttc.l1a_counter, tbl[i].cnt);
            chk($sformatf("tbl%0d_lost", i), 32'(ttc.l1a_lost), 32'(tbl[i].lost));
            chk($sformatf("tbl%0d_orbit", i), ttc.orbit_counter, tbl[i].orbit);
            chk($sformatf("tbl%0d_resync", i), 32'(ttc.ttc_resync), 32'd0);
        end
        ttc.l1a_req = 1'b0;

        // Two full orbits plus one clock: bx0 exactly at bxn 0, three orbits counted
        ttc.enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ttc.enable = 1'b1;
        err = 0; nbx0 = 0; nrsy = 0; nl1a = 0;
        for (int k = 1; k <= 7129; k++) begin
            tick();
            exp_bxn = (k - 1) % 3564;
            if (ttc.bxn_counter != 12'(exp_bxn)) err++;
            if (ttc.ttc_bx0 != (exp_bxn == 0)) err++;
            if (ttc.ttc_bx0) nbx0++;
            if (ttc.ttc_resync) nrsy++;
            if (ttc.ttc_l1a) nl1a++;
        end
        chk("orbit_bxn_bx0_errors", 32'(err), 32'd0);
        chk("orbit_bx0_count", 32'(nbx0), 32'd3);
        chk("orbit_counter_3", ttc.orbit_counter, 32'd3);
        chk("orbit_no_resync", 32'(nrsy), 32'd0);
        chk("orbit_no_l1a", 32'(nl1a), 32'd0);
        ttc.enable = 1'b0;
        tick();
        chk("idle_bxn", 32'(ttc.bxn_counter), 32'd0);
        chk("idle_orbit_held", ttc.orbit_counter, 32'd3);

        // Resync requested at bxn 100 goes out at bxn 3563 of the same orbit
        ttc.enable = 1'b1;
        tick();
        wait_bxn(50, 100);
        ttc.l1a_req = 1'b1;
        tick();
        ttc.l1a_req = 1'b0;
        chk("pre_rsy_l1a_cnt", ttc.l1a_counter, 32'd1);
        wait_bxn(100, 100);
        ttc.resync_req = 1'b1;
        tick();
        ttc.resync_req = 1'b0;
        chk("rsy_pending_set", 32'(ttc.resync_pending), 32'd1);
        chk("rsy_not_yet", 32'(ttc.ttc_resync), 32'd0);
        nbx0 = 0;
        n = 0;
        while (!ttc.ttc_resync && (n < 4000)) begin
            tick();
            n++;
            if (ttc.ttc_bx0) nbx0++;
        end
        chk("rsy_seen", 32'(ttc.ttc_resync), 32'd1);
        chk("rsy_bxn", 32'(ttc.bxn_counter), 32'd3563);
        chk("rsy_same_orbit", 32'(nbx0), 32'd0);
        chk("rsy_orbit_zero", ttc.orbit_counter, 32'd0);
        chk("rsy_l1a_cnt_zero", ttc.l1a_counter, 32'd0);
        chk("rsy_pending_clr", 32'(ttc.resync_pending), 32'd0);
        tick();
        chk("post_rsy_bx0", 32'(ttc.ttc_bx0), 32'd1);
        chk("post_rsy_bxn", 32'(ttc.bxn_counter), 32'd0);
        chk("post_rsy_orbit", ttc.orbit_counter, 32'd1);
        chk("post_rsy_no_resync", 32'(ttc.ttc_resync), 32'd0);
        for (int k = 0; k < 9; k++) tick();
        ttc.l1a_req = 1'b1;
        tick();
        ttc.l1a_req = 1'b0;
        n = 11;
        while (!ttc.ttc_l1a && (n < 500)) begin
            tick();
            n++;
        end
        chk("quiet_l1a_offset", 32'(n), 32'd400);
        chk("quiet_l1a_cnt", ttc.l1a_counter, 32'd1);

        // Request at bxn 3563 waits a full orbit
        wait_bxn(3563, 4000);
        ttc.resync_req = 1'b1;
        tick();
        ttc.resync_req = 1'b0;
        chk("late_req_bxn0", 32'(ttc.bxn_counter), 32'd0);
        wait_resync(8000, n);
        chk("late_req_delay", 32'(n), 32'd3563);
        chk("late_req_bxn", 32'(ttc.bxn_counter), 32'd3563);
        for (int k = 0; k < 400; k++) tick();
        // Enable dropped in RSY_WAIT cancels the resync
        ttc.resync_req = 1'b1;
        tick();
        ttc.resync_req = 1'b0;
        chk("drop_pending_set", 32'(ttc.resync_pending), 32'd1);
        ttc.enable = 1'b0;
        tick();
        chk("drop_pending_clr", 32'(ttc.resync_pending), 32'd0);
        chk("drop_bxn", 32'(ttc.bxn_counter), 32'd0);
        ttc.enable = 1'b1;
        nrsy = 0;
        for (int k = 0; k < 3700; k++) begin
            tick();
            if (ttc.ttc_resync) nrsy++;
        end
        chk("drop_no_resync", 32'(nrsy), 32'd0);

        // Reset pulse during QUIET, with an L1A pending and one lost
        ttc.resync_req = 1'b1;
        tick();
        ttc.resync_req = 1'b0;
        wait_resync(4000, n);
        for (int k = 0; k < 5; k++) tick();
        ttc.l1a_req = 1'b1;
        tick();
        tick();
        ttc.l1a_req = 1'b0;
        tick();
        chk("quiet_lost", 32'(ttc.l1a_lost), 32'd1);
        chk("quiet_no_l1a", 32'(ttc.ttc_l1a), 32'd0);
        reset = 1'b1;
        tick();
        chk("qrst_bx0", 32'(ttc.ttc_bx0), 32'd0);
        chk("qrst_resync", 32'(ttc.ttc_resync), 32'd0);
        chk("qrst_l1a", 32'(ttc.ttc_l1a), 32'd0);
        chk("qrst_bxn", 32'(ttc.bxn_counter), 32'd0);
        chk("qrst_orbit", ttc.orbit_counter, 32'd0);
        chk("qrst_l1a_cnt", ttc.l1a_counter, 32'd0);
        chk("qrst_lost", 32'(ttc.l1a_lost), 32'd0);
        chk("qrst_pending", 32'(ttc.resync_pending), 32'd0);
        reset = 1'b0;
        tick();
        chk("qrst_run_bx0", 32'(ttc.ttc_bx0), 32'd1);
        chk("qrst_run_bxn", 32'(ttc.bxn_counter), 32'd0);
        chk("qrst_run_orbit", ttc.orbit_counter, 32'd1);
        chk("qrst_run_no_l1a", 32'(ttc.ttc_l1a), 32'd0);

        // Periodic L1A, period 10 over 1001 RUN clocks
        ttc.enable = 1'b0;
        reset = 1'b1;
        ttc.l1a_period = 16'd10;
        tick();
        reset = 1'b0;
        ttc.enable = 1'b1;
        nl1a = 0;
        first = 0;
        for (int k = 1; k <= 1001; k++) begin
            tick();
            if (ttc.ttc_l1a) begin
                nl1a++;
                if (first == 0) first = k;
            end
        end
        ttc.enable = 1'b0;
        tick();
        ttc.l1a_period = 16'd0;
        chk("per_l1a_seen", 32'(nl1a), 32'(EXP_PER));
        chk("per_l1a_cnt", ttc.l1a_counter, 32'(EXP_PER));
        chk("per_first_l1a", 32'(first), (EXP_PER != 0) ? 32'd11 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
